udp_wave_unpack: RTL and testbench

- Sits directly downstream of the UDP receive stage and consumes its per-byte payload stream and its packet-done strobe and source tag.
- Checks each packet's 2-byte payload header (sync byte, then sequence byte).
- Packs the remaining bytes big-endian into 16-bit samples and emits them with a per-channel write address (channel A or B) into frame buffers of FRAME_LEN samples.
- Flags malformed or aborted packets and counts good packets per channel.

---
 rtl/udp_wave_unpack_if.sv | 16 +
 rtl/udp_wave_unpack.sv | 199 +++++++++++++++++++
 tb/tb_udp_wave_unpack.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/udp_wave_unpack_if.sv
// Per-byte payload stream from the UDP receive stage into udp_wave_unpack.
// Signal names match the original flat ports so existing hookups carry over.
interface udp_wave_unpack_if;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [1:0]  wave_source;

    modport master (
        output rec_en, rec_data, rec_pkt_done, rec_byte_num, wave_source
    );
    modport slave (
        input rec_en, rec_data, rec_pkt_done, rec_byte_num, wave_source
    );
endinterface

// File: rtl/udp_wave_unpack.sv
// Unpacks UDP waveform payloads (sync, seq, big-endian 16-bit samples) into per-channel frame writes.
// Optional macro UDP_WAVE_SEQ_CHECK_EN enables sequence checking with frame restart on mismatch.
module udp_wave_unpack #(
    parameter int          FRAME_LEN = 1024,
    parameter int          AW        = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_wave_unpack_if.slave     rec,
    output logic                 smp_valid,
    output logic                 smp_ch,
    output logic [AW-1:0]        smp_addr,
    output logic [15:0]          smp_data,
    output logic [1:0]           frame_done,
    output logic                 pkt_err,
    output logic                 seq_err,
    output logic [15:0]          pkt_cnt_a,
    output logic [15:0]          pkt_cnt_b
);

    typedef enum logic [1:0] {IDLE, SEQ, DATA, DROP} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    state_t        state, state_nxt;
    logic          ch, ch_nxt;
    logic [7:0]    hi_byte, hi_byte_nxt;
    logic          hi_pend, hi_pend_nxt;
    logic [AW-1:0] addr [2];
    logic [AW-1:0] addr_nxt [2];
    logic [7:0]    exp_seq [2];
    logic [7:0]    exp_seq_nxt [2];
`ifdef UDP_WAVE_SEQ_CHECK_EN
    logic [1:0]    seen, seen_nxt;
`endif

    logic          smp_valid_nxt, smp_ch_nxt, pkt_err_nxt, seq_err_nxt;
    logic [AW-1:0] smp_addr_nxt;
    logic [15:0]   smp_data_nxt, pkt_cnt_a_nxt, pkt_cnt_b_nxt;
    logic [1:0]    frame_done_nxt;

    // Payload length is informational only.
    logic unused_byte_num;
    assign unused_byte_num = ^rec.rec_byte_num;

    always_comb begin
        state_nxt      = state;
        ch_nxt         = ch;
        hi_byte_nxt    = hi_byte;
        hi_pend_nxt    = hi_pend;
        addr_nxt       = addr;
        exp_seq_nxt    = exp_seq;
`ifdef UDP_WAVE_SEQ_CHECK_EN
        seen_nxt       = seen;
`endif
        smp_valid_nxt  = 1'b0;
        smp_ch_nxt     = smp_ch;
        smp_addr_nxt   = smp_addr;
        smp_data_nxt   = smp_data;
        frame_done_nxt = '0;
        pkt_err_nxt    = 1'b0;
        seq_err_nxt    = 1'b0;
        pkt_cnt_a_nxt  = pkt_cnt_a;
        pkt_cnt_b_nxt  = pkt_cnt_b;

        unique case (state)
            IDLE: begin
                if (rec.rec_en) begin
                    if (rec.wave_source == 2'b01 || rec.wave_source == 2'b10) begin
                        ch_nxt = rec.wave_source[1];
                        if (rec.rec_data == SYNC_BYTE) begin
                            state_nxt = SEQ;
                        end else begin
                            pkt_err_nxt = 1'b1;
                            state_nxt   = DROP;
                        end
                    end else begin
                        pkt_err_nxt = 1'b1;
                        state_nxt   = DROP;
                    end
                    if (rec.rec_pkt_done) begin
                        pkt_err_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            SEQ: begin
                if (!rec.rec_en) begin
                    pkt_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    exp_seq_nxt[ch] = rec.rec_data + 8'd1;
                    hi_pend_nxt     = 1'b0;
                    state_nxt       = DATA;
`ifdef UDP_WAVE_SEQ_CHECK_EN
                    if (seen[ch] && rec.rec_data != exp_seq[ch]) begin
                        seq_err_nxt  = 1'b1;
                        addr_nxt[ch] = '0;
                    end
                    seen_nxt[ch] = 1'b1;
`endif
                    // Done on the seq byte is a header-only packet: zero samples, counted as good.
                    if (rec.rec_pkt_done) begin
                        state_nxt = IDLE;
                        if (ch) pkt_cnt_b_nxt = pkt_cnt_b + 16'd1;
                        else    pkt_cnt_a_nxt = pkt_cnt_a + 16'd1;
                    end
                end
            end
            DATA: begin
                if (!rec.rec_en) begin
                    pkt_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    if (!hi_pend) begin
                        hi_byte_nxt = rec.rec_data;
                        hi_pend_nxt = 1'b1;
                    end else begin
                        hi_pend_nxt   = 1'b0;
                        smp_valid_nxt = 1'b1;
                        smp_ch_nxt    = ch;
                        smp_addr_nxt  = addr[ch];
                        smp_data_nxt  = {hi_byte, rec.rec_data};
                        if (addr[ch] == LAST_ADDR) begin
                            addr_nxt[ch]       = '0;
                            frame_done_nxt[ch] = 1'b1;
                        end else begin
                            addr_nxt[ch] = addr[ch] + AW'(1);
                        end
                    end
                    // A done on a high byte leaves an odd byte pending: the packet is bad.
                    if (rec.rec_pkt_done) begin
                        state_nxt = IDLE;
                        if (!hi_pend) begin
                            pkt_err_nxt = 1'b1;
                            hi_pend_nxt = 1'b0;
                        end else if (ch) begin
                            pkt_cnt_b_nxt = pkt_cnt_b + 16'd1;
                        end else begin
                            pkt_cnt_a_nxt = pkt_cnt_a + 16'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (!rec.rec_en || rec.rec_pkt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= 1'b0;
            hi_byte    <= '0;
            hi_pend    <= 1'b0;
            addr[0]    <= '0;
            addr[1]    <= '0;
            exp_seq[0] <= '0;
            exp_seq[1] <= '0;
`ifdef UDP_WAVE_SEQ_CHECK_EN
            seen       <= '0;
`endif
            smp_valid  <= 1'b0;
            smp_ch     <= 1'b0;
            smp_addr   <= '0;
            smp_data   <= '0;
            frame_done <= '0;
            pkt_err    <= 1'b0;
            seq_err    <= 1'b0;
            pkt_cnt_a  <= '0;
            pkt_cnt_b  <= '0;
        end else begin
            state      <= state_nxt;
            ch         <= ch_nxt;
            hi_byte    <= hi_byte_nxt;
            hi_pend    <= hi_pend_nxt;
            addr[0]    <= addr_nxt[0];
            addr[1]    <= addr_nxt[1];
            exp_seq[0] <= exp_seq_nxt[0];
            exp_seq[1] <= exp_seq_nxt[1];
`ifdef UDP_WAVE_SEQ_CHECK_EN
            seen       <= seen_nxt;
`endif
            smp_valid  <= smp_valid_nxt;
            smp_ch     <= smp_ch_nxt;
            smp_addr   <= smp_addr_nxt;
            smp_data   <= smp_data_nxt;
            frame_done <= frame_done_nxt;
            pkt_err    <= pkt_err_nxt;
            seq_err    <= seq_err_nxt;
            pkt_cnt_a  <= pkt_cnt_a_nxt;
            pkt_cnt_b  <= pkt_cnt_b_nxt;
        end
    end

endmodule

// File: tb/tb_udp_wave_unpack.sv
// Directed bench for udp_wave_unpack with FRAME_LEN=4; expectations follow UDP_WAVE_SEQ_CHECK_EN.
module tb_udp_wave_unpack;
    localparam int FL = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          smp_valid, smp_ch, pkt_err, seq_err;
    logic [AW-1:0] smp_addr;
    logic [15:0]   smp_data, pkt_cnt_a, pkt_cnt_b;
    logic [1:0]    frame_done;

    udp_wave_unpack_if rec_bus ();

    udp_wave_unpack #(.FRAME_LEN(FL), .AW(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rec        (rec_bus),
        .smp_valid  (smp_valid),
        .smp_ch     (smp_ch),
        .smp_addr   (smp_addr),
        .smp_data   (smp_data),
        .frame_done (frame_done),
        .pkt_err    (pkt_err),
        .seq_err    (seq_err),
        .pkt_cnt_a  (pkt_cnt_a),
        .pkt_cnt_b  (pkt_cnt_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc = 0;
    int last_err_cyc = -1;
    int n_perr, n_serr, n_fd;
    logic [20:0] smp_q [$];
    logic [7:0]  pkt_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Entry layout: {frame_done[1:0], ch, addr[1:0], data[15:0]}
    always @(negedge clk) begin
        if (rst_n) begin
            if (smp_valid) smp_q.push_back({frame_done, smp_ch, smp_addr, smp_data});
            if (pkt_err) begin
                n_perr++;
                last_err_cyc = cyc;
            end
            if (seq_err) n_serr++;
            n_fd += int'(frame_done[0]) + int'(frame_done[1]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        smp_q.delete();
        n_perr = 0;
        n_serr = 0;
        n_fd   = 0;
    endtask

    task automatic pop_smp(input string tag, input logic [20:0] exp);
        logic [20:0] e;
        e = (smp_q.size() > 0) ? smp_q.pop_front() : '1;
        check(tag, 32'(e), 32'(exp));
    endtask

    task automatic send(input logic [1:0] src, input bit with_done);
        for (int i = 0; i < pkt_q.size(); i++) begin
            @(posedge clk); #1;
            rec_bus.rec_en       = 1'b1;
            rec_bus.rec_data     = pkt_q[i];
            rec_bus.wave_source  = src;
            rec_bus.rec_byte_num = 16'(pkt_q.size());
            rec_bus.rec_pkt_done = with_done && (i == pkt_q.size() - 1);
            if (rec_bus.rec_pkt_done) done_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        rec_bus.rec_en       = 1'b0;
        rec_bus.rec_pkt_done = 1'b0;
        rec_bus.wave_source  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rec_bus.rec_en = 1'b0;
        rec_bus.rec_data = '0;
        rec_bus.rec_pkt_done = 1'b0;
        rec_bus.rec_byte_num = '0;
        rec_bus.wave_source = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(smp_valid), 0);
        check("rst_fd",    32'(frame_done), 0);
        check("rst_err",   32'({pkt_err, seq_err}), 0);
        check("rst_cnt",   32'({pkt_cnt_a, pkt_cnt_b}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic channel A packet
        clear_log();
        pkt_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        send(2'b01, 1'b1);
        check("t1_nsmp", smp_q.size(), 2);
        pop_smp("t1_s0", {2'b00, 1'b0, 2'd0, 16'h1234});
        pop_smp("t1_s1", {2'b00, 1'b0, 2'd1, 16'h5678});
        check("t1_cnt_a", 32'(pkt_cnt_a), 1);
        check("t1_err", n_perr + n_serr, 0);

        // Channel B frame wrap
        clear_log();
        pkt_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A};
        send(2'b10, 1'b1);
        check("t2_nsmp", smp_q.size(), 5);
        pop_smp("t2_s0", {2'b00, 1'b1, 2'd0, 16'h0102});
        pop_smp("t2_s1", {2'b00, 1'b1, 2'd1, 16'h0304});
        pop_smp("t2_s2", {2'b00, 1'b1, 2'd2, 16'h0506});
        pop_smp("t2_s3", {2'b10, 1'b1, 2'd3, 16'h0708});
        pop_smp("t2_s4", {2'b00, 1'b1, 2'd0, 16'h090A});
        check("t2_cnt_b", 32'(pkt_cnt_b), 1);
        check("t2_cnt_a", 32'(pkt_cnt_a), 1);

        // Odd sample-byte count
        clear_log();
        pkt_q = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        send(2'b01, 1'b1);
        check("t3_nsmp", smp_q.size(), 1);
        pop_smp("t3_s0", {2'b00, 1'b0, 2'd2, 16'hAABB});
        check("t3_nerr", n_perr, 1);
        check("t3_err_cyc", last_err_cyc, done_cyc);
        check("t3_serr", n_serr, 0);
        check("t3_cnt_a", 32'(pkt_cnt_a), 1);

        // Bad sync byte, then invalid source
        clear_log();
        pkt_q = '{8'h5A, 8'h00, 8'h11, 8'h22};
        send(2'b01, 1'b1);
        check("t4a_nerr", n_perr, 1);
        check("t4a_nsmp", smp_q.size(), 0);
        clear_log();
        pkt_q = '{8'hA5, 8'h02, 8'h11, 8'h22};
        send(2'b00, 1'b1);
        check("t4b_nerr", n_perr, 1);
        check("t4b_nsmp", smp_q.size(), 0);
        clear_log();
        pkt_q = '{8'hA5, 8'h02, 8'hCA, 8'hFE};
        send(2'b01, 1'b1);
        check("t4c_nsmp", smp_q.size(), 1);
        pop_smp("t4c_s0", {2'b01, 1'b0, 2'd3, 16'hCAFE});
        check("t4c_cnt_a", 32'(pkt_cnt_a), 2);
        check("t4c_err", n_perr + n_serr, 0);

        // Abort mid-DATA on channel B, then resume
        clear_log();
        pkt_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE};
        send(2'b10, 1'b0);
        check("t5_nsmp", smp_q.size(), 1);
        pop_smp("t5_s0", {2'b00, 1'b1, 2'd1, 16'hDEAD});
        check("t5_nerr", n_perr, 1);
        check("t5_cnt_b", 32'(pkt_cnt_b), 1);
        clear_log();
        pkt_q = '{8'hA5, 8'h02, 8'h12, 8'h34};
        send(2'b10, 1'b1);
        pop_smp("t5b_s0", {2'b00, 1'b1, 2'd2, 16'h1234});
        check("t5b_cnt_b", 32'(pkt_cnt_b), 2);
        check("t5b_nerr", n_perr, 0);

        // Sequence handling after a fresh reset
        do_reset();
        rst_n = 1'b1;
        check("t6_rst_cnt", 32'({pkt_cnt_a, pkt_cnt_b}), 0);
        clear_log();
        pkt_q = '{8'hA5, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
        send(2'b01, 1'b1);
        pop_smp("t6_s0", {2'b00, 1'b0, 2'd0, 16'h1111});
        pop_smp("t6_s1", {2'b00, 1'b0, 2'd1, 16'h2222});
        check("t6_serr0", n_serr, 0);
        clear_log();
        pkt_q = '{8'hA5, 8'h02, 8'h33, 8'h33};
        send(2'b01, 1'b1);
`ifdef UDP_WAVE_SEQ_CHECK_EN
        check("t6_serr1", n_serr, 1);
        pop_smp("t6_s2", {2'b00, 1'b0, 2'd0, 16'h3333});
`else
        check("t6_serr1", n_serr, 0);
        pop_smp("t6_s2", {2'b00, 1'b0, 2'd2, 16'h3333});
`endif
        check("t6_nerr", n_perr, 0);
        check("t6_cnt_a", 32'(pkt_cnt_a), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
